// File: rtl/sad_accum_pipe.sv
// Multi-lane sum-of-absolute-differences engine: per-lane |a-b|, registered lane
// reduction, windowed saturating accumulation, and a held valid/ready result.
module sad_accum_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [LANES*WIDTH-1:0]   in_a,
  input  logic [LANES*WIDTH-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         out_count
);

  localparam int SUM_W = WIDTH + $clog2(LANES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                         stall_s, adv_s;
  logic                         s0_valid_r, s0_first_r, s0_last_r;
  logic [LANES*WIDTH-1:0]       s0_a_r, s0_b_r;
  logic                         s1_valid_r, s1_first_r, s1_last_r;
  logic [LANES-1:0][WIDTH-1:0]  s1_abs_r, abs_s;
  logic [WIDTH:0]               diff_s, neg_s;
  logic                         s2_valid_r, s2_first_r, s2_last_r;
  logic [SUM_W-1:0]             s2_sum_r, sum_s;
  logic [ACC_W-1:0]             acc_r, base_s, acc_nxt_s;
  logic [ACC_W:0]               total_s;
  logic [CNT_W-1:0]             cnt_r, cnt_nxt_s;
  logic                         sat_r, sat_nxt_s, ovf_s, start_s, prev_last_r;
  logic                         out_valid_r, out_sat_r;
  logic [ACC_W-1:0]             out_sum_r;
  logic [CNT_W-1:0]             out_count_r;

  // A held, unconsumed result freezes the whole pipe.
  assign stall_s   = out_valid_r & ~out_ready;
  assign adv_s     = ~stall_s;
  assign in_ready  = adv_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_sat   = out_sat_r;
  assign out_count = out_count_r;

  // S0: capture accepted input beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_r <= 1'b0;
      s0_first_r <= 1'b0;
      s0_last_r  <= 1'b0;
      s0_a_r     <= '0;
      s0_b_r     <= '0;
    end else if (adv_s) begin
      s0_valid_r <= in_valid;
      if (in_valid) begin
        s0_first_r <= in_first;
        s0_last_r  <= in_last;
        s0_a_r     <= in_a;
        s0_b_r     <= in_b;
      end
    end
  end

  // Per-lane absolute difference from a WIDTH+1 bit two's-complement difference
  always_comb begin
    abs_s  = '0;
    diff_s = '0;
    neg_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      diff_s = {1'b0, s0_a_r[i*WIDTH +: WIDTH]} - {1'b0, s0_b_r[i*WIDTH +: WIDTH]};
      neg_s  = ~diff_s + {{WIDTH{1'b0}}, 1'b1};
      if (diff_s[WIDTH]) begin
        abs_s[i] = neg_s[WIDTH-1:0];
      end else begin
        abs_s[i] = diff_s[WIDTH-1:0];
      end
    end
  end

  // S1: register lane magnitudes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_abs_r   <= '0;
    end else if (adv_s) begin
      s1_valid_r <= s0_valid_r;
      s1_first_r <= s0_first_r;
      s1_last_r  <= s0_last_r;
      s1_abs_r   <= abs_s;
    end
  end

  // Lane reduction; SUM_W bits always hold LANES * (2^WIDTH-1)
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_s = sum_s + SUM_W'(s1_abs_r[i]);
    end
  end

  // S2: register beat sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_sum_r   <= '0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_first_r <= s1_first_r;
      s2_last_r  <= s1_last_r;
      s2_sum_r   <= sum_s;
    end
  end

  // Next accumulator state: restart on first or after a closed window, else saturating add
  always_comb begin
    start_s = s2_first_r | prev_last_r;
    base_s  = start_s ? {ACC_W{1'b0}} : acc_r;
    total_s = {1'b0, base_s} + (ACC_W+1)'(s2_sum_r);
    ovf_s   = total_s[ACC_W];
    if (ovf_s) begin
      acc_nxt_s = {ACC_W{1'b1}};
    end else begin
      acc_nxt_s = total_s[ACC_W-1:0];
    end
    if (start_s) begin
      cnt_nxt_s = CNT_ONE;
    end else if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
    sat_nxt_s = (start_s ? 1'b0 : sat_r) | ovf_s;
  end

  // S3: accumulator and held result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r       <= '0;
      cnt_r       <= '0;
      sat_r       <= 1'b0;
      prev_last_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_count_r <= '0;
      out_sat_r   <= 1'b0;
    end else if (adv_s) begin
      if (s2_valid_r) begin
        acc_r       <= acc_nxt_s;
        cnt_r       <= cnt_nxt_s;
        sat_r       <= sat_nxt_s;
        prev_last_r <= s2_last_r;
      end
      out_valid_r <= s2_valid_r & s2_last_r;
      if (s2_valid_r & s2_last_r) begin
        out_sum_r   <= acc_nxt_s;
        out_count_r <= cnt_nxt_s;
        out_sat_r   <= sat_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_sad_accum_pipe.sv
// Scoreboard bench for sad_accum_pipe: two instances (ACC_W=20 and ACC_W=11) share
// one input stream; a monitor pops hand-computed results on every output handshake.
module tb_sad_accum_pipe;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_first, in_last, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, out_sat;
  logic [19:0] out_sum;
  logic [7:0]  out_count;
  logic        in_ready11, out_valid11, out_sat11;
  logic [10:0] out_sum11;
  logic [7:0]  out_count11;

  exp_t q20[$];
  exp_t q11[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] C1A = 32'hFF00C80A;  // lanes 10,200,0,255
  localparam logic [31:0] C1B = 32'h00006414;  // lanes 20,100,0,0   -> 365
  localparam logic [31:0] V8A = 32'h04030201;
  localparam logic [31:0] V8B = 32'h01020304;  // -> 3+1+1+3 = 8
  localparam logic [31:0] XA  = 32'hFFFFFFFF;
  localparam logic [31:0] XB  = 32'h00000000;  // -> 1020

  sad_accum_pipe #(.WIDTH(8), .LANES(4), .ACC_W(20), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_sat(out_sat), .out_count(out_count));

  sad_accum_pipe #(.WIDTH(8), .LANES(4), .ACC_W(11), .CNT_W(8)) dut11 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready11),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid11), .out_ready(out_ready), .out_sum(out_sum11),
    .out_sat(out_sat11), .out_count(out_count11));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] s20, input logic t20,
                          input logic [31:0] s11, input logic t11, input logic [31:0] c);
    exp_t e;
    e.sum = s20; e.sat = t20; e.cnt = c;
    q20.push_back(e);
    e.sum = s11; e.sat = t11;
    q11.push_back(e);
  endtask

  // Present a beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic beat(input logic f, input logic l, input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   budget;
    in_valid = 1'b1; in_first = f; in_last = l; in_a = a; in_b = b;
    rdy = 1'b0;
    budget = 50;
    while (!rdy && budget > 0) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    check("accept_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: the handshake seen here completes on the following rising edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      check("result_expected20", 32'(q20.size() > 0), 32'd1);
      if (q20.size() > 0) begin
        e = q20.pop_front();
        check("sum20", 32'(out_sum), e.sum);
        check("count20", 32'(out_count), e.cnt);
        check("sat20", 32'(out_sat), 32'(e.sat));
      end
    end
    if (!rst && out_valid11 && out_ready) begin
      check("result_expected11", 32'(q11.size() > 0), 32'd1);
      if (q11.size() > 0) begin
        e = q11.pop_front();
        check("sum11", 32'(out_sum11), e.sum);
        check("count11", 32'(out_count11), e.cnt);
        check("sat11", 32'(out_sat11), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ov;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Case 1: single-beat window and its latency
    push_exp(32'd365, 1'b0, 32'd365, 1'b0, 32'd1);
    beat(1'b1, 1'b1, C1A, C1B);
    in_valid = 1'b0;
    check("lat_t0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t2", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t3", 32'(out_valid), 32'd1);
    idle(4);

    // Case 2: three back-to-back beats, one result, valid for exactly one cycle
    push_exp(32'd1095, 1'b0, 32'd1095, 1'b0, 32'd3);
    beat(1'b1, 1'b0, C1A, C1B);
    beat(1'b0, 1'b0, C1A, C1B);
    beat(1'b0, 1'b1, C1A, C1B);
    in_valid = 1'b0;
    n_ov = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) n_ov++;
    end
    check("valid_one_cycle", 32'(n_ov), 32'd1);

    // Case 3: held result under backpressure, second window queued behind it
    out_ready = 1'b0;
    push_exp(32'd365, 1'b0, 32'd365, 1'b0, 32'd1);
    beat(1'b1, 1'b1, C1A, C1B);
    idle(3);
    push_exp(32'd8, 1'b0, 32'd8, 1'b0, 32'd1);
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_a = V8A; in_b = V8B;
    for (int i = 0; i < 5; i++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_in_ready11", 32'(in_ready11), 32'd0);
      check("stall_out_sum", 32'(out_sum), 32'd365);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    beat(1'b1, 1'b1, V8A, V8B);
    idle(6);

    // Case 4: saturation in the narrow instance, cleared by the next window
    push_exp(32'd3060, 1'b0, 32'd2047, 1'b1, 32'd3);
    beat(1'b1, 1'b0, XA, XB);
    beat(1'b0, 1'b0, XA, XB);
    beat(1'b0, 1'b1, XA, XB);
    push_exp(32'd365, 1'b0, 32'd365, 1'b0, 32'd1);
    beat(1'b1, 1'b1, C1A, C1B);
    idle(6);

    // Case 5: first mid-window abandons the open window
    push_exp(32'd1385, 1'b0, 32'd1385, 1'b0, 32'd2);
    beat(1'b1, 1'b0, XA, XB);
    beat(1'b0, 1'b0, V8A, V8B);
    beat(1'b1, 1'b0, C1A, C1B);
    beat(1'b0, 1'b1, XA, XB);
    idle(6);

    // Case 6a: asynchronous reset drops a held result
    out_ready = 1'b0;
    beat(1'b1, 1'b1, C1A, C1B);
    idle(3);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(out_sum), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // Case 6b: reset with beats in flight; a following non-first beat sees a clean accumulator
    beat(1'b1, 1'b0, XA, XB);
    beat(1'b0, 1'b0, XA, XB);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid_b", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(32'd365, 1'b0, 32'd365, 1'b0, 32'd1);
    beat(1'b0, 1'b1, C1A, C1B);
    push_exp(32'd365, 1'b0, 32'd365, 1'b0, 32'd1);
    beat(1'b1, 1'b1, C1A, C1B);
    idle(8);

    check("scoreboard_drained", 32'(q20.size() + q11.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
